// File: rtl/mdio_phy_resp.sv
// mdio_phy_resp: Clause 22 MDIO management slave with a 32 x 16 register file.
// MDC is oversampled on clk, and every decode step happens on a synchronized MDC rising edge.
// Read data is launched on the bit edge and held for one full MDC period.
module mdio_phy_resp #(
    parameter logic [4:0]  PHY_ADDR = 5'h04,
    parameter int          PRE_LEN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h001C,
    parameter logic [15:0] PHY_ID2  = 16'hC916,
    parameter logic [15:0] REG0_RST = 16'h1140
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        soft_rst,
    output logic        frame_err
);

    localparam logic [15:0] REG1_RST   = 16'h796D;
    localparam logic [5:0]  PRE_TARGET = 6'(PRE_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t state, state_nxt;

    logic        mdc_s1, mdc_s2, mdc_s3;
    logic        mdio_s1, mdio_s2;
    logic        bit_edge, bit_in;

    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic        op_msb, ta_msb, is_read, addr_match;
    logic        op_valid, phy_match;
    logic [4:0]  phyad_sr, regad_sr, regad_full;
    logic [15:0] data_sr, shift_reg, rd_word;
    logic [15:0] regs [32];

    logic        commit, commit_soft;
    logic [15:0] commit_data;

    logic        mdio_o_nxt, mdio_oe_nxt;
    logic        wr_strobe_nxt, soft_rst_nxt, frame_err_nxt;
    logic [4:0]  wr_addr_nxt;
    logic [15:0] wr_data_nxt;

    function automatic logic [15:0] reset_value(input logic [4:0] idx);
        case (idx)
            5'd0:    return REG0_RST;
            5'd1:    return REG1_RST;
            5'd2:    return PHY_ID1;
            5'd3:    return PHY_ID2;
            default: return 16'h0000;
        endcase
    endfunction

    assign bit_edge    = mdc_s2 & ~mdc_s3;
    assign bit_in      = mdio_s2;
    assign regad_full  = {regad_sr[3:0], bit_in};
    assign phy_match   = (phyad_sr == PHY_ADDR);
    assign op_valid    = op_msb ^ bit_in;
    assign commit_data = {data_sr[14:0], bit_in};
    assign commit      = bit_edge && (state == S_DATA) && (bit_cnt == 4'd15)
                         && addr_match && !is_read;
    assign commit_soft = commit && (regad_sr == 5'd0) && commit_data[15];

    // Synchronizers are left out of reset so a held-high MDC does not look like a fresh edge after rst.
    always_ff @(posedge clk) begin
        mdc_s1  <= mdc;
        mdc_s2  <= mdc_s1;
        mdc_s3  <= mdc_s2;
        mdio_s1 <= mdio_i;
        mdio_s2 <= mdio_s1;
    end

    // State register: advances only on synchronized MDC rising edges.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (bit_edge)
            state <= state_nxt;
    end

    // Next-state decode of the Clause 22 frame fields.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bit_in && (pre_cnt >= PRE_TARGET - 6'd1)) state_nxt = S_PRE;
            S_PRE:   if (!bit_in) state_nxt = S_ST;
            S_ST:    state_nxt = bit_in ? S_OP : S_IDLE;
            S_OP:    if (bit_cnt == 4'd1) state_nxt = op_valid ? S_PHYAD : S_IDLE;
            S_PHYAD: if (bit_cnt == 4'd4) state_nxt = S_REGAD;
            S_REGAD: if (bit_cnt == 4'd4) state_nxt = S_TA;
            S_TA:    if (bit_cnt == 4'd1) state_nxt = S_DATA;
            S_DATA:  if (bit_cnt == 4'd15) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Field capture, preamble counting and read shift register; the counter only survives in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= 6'd0;
            bit_cnt    <= 4'd0;
            op_msb     <= 1'b0;
            ta_msb     <= 1'b0;
            is_read    <= 1'b0;
            addr_match <= 1'b0;
            phyad_sr   <= 5'd0;
            regad_sr   <= 5'd0;
            data_sr    <= 16'd0;
            shift_reg  <= 16'd0;
        end else if (bit_edge) begin
            bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
            if (state == S_IDLE)
                pre_cnt <= bit_in ? ((pre_cnt == PRE_TARGET) ? pre_cnt : pre_cnt + 6'd1) : 6'd0;
            else
                pre_cnt <= 6'd0;
            case (state)
                S_OP: begin
                    if (bit_cnt == 4'd0)
                        op_msb <= bit_in;
                    else
                        is_read <= op_msb & ~bit_in;
                end
                S_PHYAD: phyad_sr <= {phyad_sr[3:0], bit_in};
                S_REGAD: begin
                    regad_sr <= regad_full;
                    if (bit_cnt == 4'd4) begin
                        addr_match <= phy_match;
                        shift_reg  <= rd_word;
                    end
                end
                S_TA: begin
                    if (bit_cnt == 4'd0)
                        ta_msb <= bit_in;
                    else if (is_read)
                        shift_reg <= {shift_reg[14:0], 1'b0};
                end
                S_DATA: begin
                    data_sr <= {data_sr[14:0], bit_in};
                    if (is_read)
                        shift_reg <= {shift_reg[14:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Read mux; register 1 bit 2 always reflects live link status.
    always_comb begin
        rd_word = regs[regad_full];
        if (regad_full == 5'd1)
            rd_word[2] = link_up;
    end

    // Register file: soft reset restores every register, and registers 1-3 ignore writes.
    always_ff @(posedge clk) begin
        if (rst || commit_soft) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= reset_value(5'(i));
        end else if (commit && ((regad_sr == 5'd0) || (regad_sr > 5'd3))) begin
            regs[regad_sr] <= commit_data;
        end
    end

    // Output decode: MDIO drive sequencing, write commit and error pulses.
    always_comb begin
        mdio_o_nxt    = mdio_o;
        mdio_oe_nxt   = mdio_oe;
        wr_strobe_nxt = 1'b0;
        soft_rst_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        if (bit_edge) begin
            case (state)
                S_ST: if (!bit_in) frame_err_nxt = 1'b1;
                S_OP: if ((bit_cnt == 4'd1) && !op_valid) frame_err_nxt = 1'b1;
                S_TA: begin
                    if (addr_match) begin
                        if (is_read) begin
                            if (bit_cnt == 4'd0) begin
                                mdio_oe_nxt = 1'b1;
                                mdio_o_nxt  = 1'b0;
                            end else begin
                                mdio_o_nxt = shift_reg[15];
                            end
                        end else if ((bit_cnt == 4'd1) && ({ta_msb, bit_in} != 2'b10)) begin
                            frame_err_nxt = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (addr_match && is_read) begin
                        if (bit_cnt == 4'd15) begin
                            mdio_oe_nxt = 1'b0;
                            mdio_o_nxt  = 1'b0;
                        end else begin
                            mdio_o_nxt = shift_reg[15];
                        end
                    end
                    if (commit) begin
                        wr_strobe_nxt = 1'b1;
                        wr_addr_nxt   = regad_sr;
                        wr_data_nxt   = commit_data;
                        soft_rst_nxt  = commit_soft;
                    end
                end
                default: ;
            endcase
            if ((state_nxt == S_IDLE) || (state_nxt == S_PRE)) begin
                mdio_oe_nxt = 1'b0;
                mdio_o_nxt  = 1'b0;
            end
        end
    end

    // Registered outputs so the MDIO pad and strobes are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 16'd0;
            soft_rst  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mdio_o    <= mdio_o_nxt;
            mdio_oe   <= mdio_oe_nxt;
            wr_strobe <= wr_strobe_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            soft_rst  <= soft_rst_nxt;
            frame_err <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_mdio_phy_resp.sv
// tb_mdio_phy_resp: acts as the MDIO master, keeps a behavioural register model, and checks reads, writes and error pulses.
module tb_mdio_phy_resp;

    localparam logic [4:0] PHY_ADDR = 5'h04;

    logic        clk = 1'b0;
    logic        rst, mdc, master_bit, mdio_i, mdio_o, mdio_oe, link_up;
    logic        wr_strobe, soft_rst, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int checks = 0;
    int fails  = 0;
    bit jitter_en = 1'b0;

    int          strobe_cycles = 0;
    int          soft_cycles   = 0;
    int          err_cycles    = 0;
    logic [4:0]  cap_addr      = 5'd0;
    logic [15:0] cap_data      = 16'd0;

    logic [15:0] model_regs [32];
    logic        samp_o [$];
    logic        samp_oe [$];
    int          hdr_end;

    // Open-drain style line: the PHY wins while it drives, otherwise the master's value.
    assign mdio_i = mdio_oe ? mdio_o : master_bit;

    always #5 clk = ~clk;

    mdio_phy_resp dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .link_up   (link_up),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .soft_rst  (soft_rst),
        .frame_err (frame_err)
    );

    // Count pulse cycles and capture committed writes, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cycles++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (soft_rst)  soft_cycles++;
        if (frame_err) err_cycles++;
    end

    function automatic void model_reset();
        foreach (model_regs[i]) model_regs[i] = 16'h0000;
        model_regs[0] = 16'h1140;
        model_regs[1] = 16'h796D;
        model_regs[2] = 16'h001C;
        model_regs[3] = 16'hC916;
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0 && d[15])
            model_reset();
        else if (a == 5'd0 || a > 5'd3)
            model_regs[a] = d;
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] a);
        logic [15:0] v;
        v = model_regs[a];
        if (a == 5'd1) v[2] = link_up;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half_wait();
        int n;
        n = 4;
        if (jitter_en) n = 3 + $urandom_range(0, 2);
        repeat (n) @(posedge clk);
    endtask

    // One MDC period: drive the bit while MDC is low, sample the PHY just before the rising edge.
    task automatic applyStimulus(input logic b, output logic s_o, output logic s_oe);
        @(negedge clk);
        mdc        = 1'b0;
        master_bit = b;
        half_wait();
        @(negedge clk);
        s_o  = mdio_o;
        s_oe = mdio_oe;
        mdc  = 1'b1;
        half_wait();
    endtask

    task automatic do_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                            input logic [15:0] wdata, input int max_slots);
        logic bits [$];
        logic so, soe;
        samp_o.delete();
        samp_oe.delete();
        bits.push_back(1'b0);
        repeat (pre_len) bits.push_back(1'b1);
        bits.push_back(st[1]);
        bits.push_back(st[0]);
        bits.push_back(op[1]);
        bits.push_back(op[0]);
        for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
        hdr_end = bits.size();
        if (op == 2'b01) begin
            bits.push_back(ta[1]);
            bits.push_back(ta[0]);
            for (int i = 15; i >= 0; i--) bits.push_back(wdata[i]);
        end else begin
            repeat (18) bits.push_back(1'b1);
        end
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size() && i < max_slots; i++) begin
            applyStimulus(bits[i], so, soe);
            samp_o.push_back(so);
            samp_oe.push_back(soe);
        end
        master_bit = 1'b1;
    endtask

    function automatic int count_oe();
        int n = 0;
        foreach (samp_oe[i]) if (samp_oe[i]) n++;
        return n;
    endfunction

    function automatic logic hdr_drive();
        logic d = 1'b0;
        for (int i = 0; i <= hdr_end; i++) d |= samp_oe[i];
        return d;
    endfunction

    function automatic logic [15:0] read_word();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[15-k] = samp_o[hdr_end + 2 + k];
        return w;
    endfunction

    task automatic check_read(input string tag, input logic [4:0] ra);
        logic [15:0] exp;
        exp = model_read(ra);
        do_frame(32, 2'b01, 2'b10, PHY_ADDR, ra, 2'b10, 16'h0000, 1000);
        checkOutput({tag, "_hdr_oe"},  {31'd0, hdr_drive()}, 32'd0);
        checkOutput({tag, "_oe_slots"}, count_oe(), 32'd17);
        checkOutput({tag, "_ta_bit"},  {31'd0, samp_o[hdr_end + 1]}, 32'd0);
        checkOutput({tag, "_data"},    {16'd0, read_word()}, {16'd0, exp});
        checkOutput({tag, "_release"}, {31'd0, samp_oe[samp_oe.size() - 1]}, 32'd0);
    endtask

    task automatic check_write(input string tag, input logic [4:0] ra, input logic [15:0] d,
                               input logic [1:0] ta);
        int s0, e0, r0;
        s0 = strobe_cycles;
        e0 = err_cycles;
        r0 = soft_cycles;
        do_frame(32, 2'b01, 2'b01, PHY_ADDR, ra, ta, d, 1000);
        repeat (2) @(negedge clk);
        checkOutput({tag, "_strobe"}, strobe_cycles - s0, 32'd1);
        checkOutput({tag, "_addr"},   {27'd0, cap_addr}, {27'd0, ra});
        checkOutput({tag, "_data"},   {16'd0, cap_data}, {16'd0, d});
        checkOutput({tag, "_err"},    err_cycles - e0, (ta != 2'b10) ? 32'd1 : 32'd0);
        checkOutput({tag, "_soft"},   soft_cycles - r0, (ra == 5'd0 && d[15]) ? 32'd1 : 32'd0);
        checkOutput({tag, "_oe"},     count_oe(), 32'd0);
        model_write(ra, d);
    endtask

    initial begin
        int          e0;
        logic [4:0]  ra;
        logic [15:0] d;

        rst        = 1'b1;
        mdc        = 1'b1;
        master_bit = 1'b1;
        link_up    = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        checkOutput("rst_oe",     {31'd0, mdio_oe},   32'd0);
        checkOutput("rst_o",      {31'd0, mdio_o},    32'd0);
        checkOutput("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        checkOutput("rst_err",    {31'd0, frame_err}, 32'd0);
        checkOutput("rst_soft",   {31'd0, soft_rst},  32'd0);
        checkOutput("rst_waddr",  {27'd0, wr_addr},   32'd0);
        checkOutput("rst_wdata",  {16'd0, wr_data},   32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset read of PHY ID 1");
        check_read("rd_reg2", 5'd2);

        $display("[TB] write then read reg4");
        check_write("wr_reg4", 5'd4, 16'hA5A5, 2'b10);
        check_read("rd_reg4", 5'd4);

        $display("[TB] address filter");
        do_frame(32, 2'b01, 2'b10, 5'd5, 5'd2, 2'b10, 16'h0000, 1000);
        checkOutput("filter_oe", count_oe(), 32'd0);
        check_read("rd_reg3_after_filter", 5'd3);

        $display("[TB] short preamble and malformed frames");
        e0 = err_cycles;
        do_frame(31, 2'b01, 2'b10, PHY_ADDR, 5'd2, 2'b10, 16'h0000, 1000);
        checkOutput("short_pre_oe",  count_oe(), 32'd0);
        checkOutput("short_pre_err", err_cycles - e0, 32'd0);
        e0 = err_cycles;
        do_frame(32, 2'b00, 2'b10, PHY_ADDR, 5'd2, 2'b10, 16'h0000, 1000);
        checkOutput("bad_st_err", err_cycles - e0, 32'd1);
        checkOutput("bad_st_oe",  count_oe(), 32'd0);
        e0 = err_cycles;
        do_frame(32, 2'b01, 2'b11, PHY_ADDR, 5'd2, 2'b10, 16'h0000, 1000);
        checkOutput("bad_op_err", err_cycles - e0, 32'd1);
        checkOutput("bad_op_oe",  count_oe(), 32'd0);
        check_write("wr_bad_ta", 5'd5, 16'h0F0F, 2'b01);
        check_read("rd_reg5", 5'd5);

        $display("[TB] protected registers, soft reset and link status");
        check_write("wr_reg2", 5'd2, 16'hFFFF, 2'b10);
        check_read("rd_reg2_kept", 5'd2);
        check_write("wr_reg4b", 5'd4, 16'h1234, 2'b10);
        check_write("wr_soft", 5'd0, 16'h8000, 2'b10);
        check_read("rd_reg4_soft", 5'd4);
        check_read("rd_reg0_soft", 5'd0);
        link_up = 1'b0;
        check_read("rd_reg1_down", 5'd1);
        link_up = 1'b1;
        check_read("rd_reg1_up", 5'd1);

        $display("[TB] randomized traffic with MDC jitter");
        jitter_en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            ra      = 5'($urandom_range(0, 31));
            d       = 16'($urandom);
            link_up = 1'($urandom_range(0, 1));
            check_write("rnd_wr", ra, d, 2'b10);
            check_read("rnd_rd", ra);
        end

        $display("[TB] reset during read data phase");
        check_write("wr_reg6", 5'd6, 16'($urandom) | 16'h0001, 2'b10);
        do_frame(32, 2'b01, 2'b10, PHY_ADDR, 5'd6, 2'b10, 16'h0000, 53);
        @(negedge clk);
        checkOutput("mid_pre_oe", {31'd0, mdio_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_oe", {31'd0, mdio_oe}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_read("rd_reg6_after_rst", 5'd6);
        check_read("rd_reg0_after_rst", 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
